// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one I2C master engine between n_req_g requesters.
// Grants one requester, latches its payload, launches the engine and returns the response.
module i2c_arbiter #(
    parameter int n_req_g   = 4,
    parameter int nbytes_g  = 3,
    parameter int timeout_g = 100000
) (
    input  logic                                clk_i,
    input  logic                                rst_n_i,
    input  logic [n_req_g-1:0]                  req_i,
    input  logic [n_req_g*$clog2(nbytes_g)-1:0] nbytes_i,
    input  logic [n_req_g*nbytes_g*8-1:0]       data_i,
    output logic [n_req_g-1:0]                  ack_o,
    output logic [n_req_g-1:0]                  rsp_valid_o,
    output logic [nbytes_g*8-1:0]               rsp_data_o,
    output logic                                rsp_err_o,
    output logic                                busy_o,
    output logic [$clog2(n_req_g)-1:0]          grant_o,
    output logic                                i2c_send_o,
    output logic [$clog2(nbytes_g)-1:0]         i2c_nbytes_o,
    output logic [nbytes_g*8-1:0]               i2c_data_o,
    input  logic [nbytes_g*8-1:0]               i2c_data_i,
    input  logic                                i2c_done_i,
    input  logic                                i2c_ready_i
);

    localparam int nbw = $clog2(nbytes_g);
    localparam int gw  = $clog2(n_req_g);
    localparam int dw  = nbytes_g * 8;
    localparam int cw  = (timeout_g > 0) ? $clog2(timeout_g + 1) : 1;

    localparam logic [n_req_g-1:0] one_lsb   = n_req_g'(1);
    localparam logic [cw-1:0]      timeout_c = cw'(timeout_g);

    typedef enum logic [1:0] {
        st_idle,
        st_launch,
        st_wait,
        st_recover
    } state_t;

    state_t        state;
    logic [gw-1:0] rr_ptr;
    logic [gw-1:0] winner;
    logic          found;
    logic [cw-1:0] wd_cnt;
    logic [cw-1:0] wd_next;
    logic          wd_expired;

    // Index of requester (base + off) modulo n_req_g.
    function automatic logic [gw-1:0] rr_index(input logic [gw-1:0] base, input int off);
        int sum;
        sum = (int'(base) + off) % n_req_g;
        return gw'(sum);
    endfunction

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        winner = rr_ptr;
        found  = 1'b0;
        for (int i = 0; i < n_req_g; i++) begin
            if (!found && req_i[rr_index(rr_ptr, i)]) begin
                winner = rr_index(rr_ptr, i);
                found  = 1'b1;
            end
        end
    end

    assign wd_next    = wd_cnt + 1'b1;
    assign wd_expired = (timeout_g > 0) && (wd_next == timeout_c);
    assign busy_o     = (state != st_idle);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= st_idle;
            rr_ptr       <= '0;
            grant_o      <= '0;
            wd_cnt       <= '0;
            ack_o        <= '0;
            rsp_valid_o  <= '0;
            rsp_data_o   <= '0;
            rsp_err_o    <= 1'b0;
            i2c_send_o   <= 1'b0;
            i2c_nbytes_o <= '0;
            i2c_data_o   <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
            ack_o       <= '0;
            i2c_send_o  <= 1'b0;
            rsp_valid_o <= '0;

            case (state)
                st_idle: begin
                    if (found && i2c_ready_i) begin
                        grant_o      <= winner;
                        i2c_nbytes_o <= nbytes_i[int'(winner)*nbw +: nbw];
                        i2c_data_o   <= data_i[int'(winner)*dw +: dw];
                        rr_ptr       <= rr_index(winner, 1);
                        wd_cnt       <= '0;
                        ack_o        <= one_lsb << winner;
                        i2c_send_o   <= 1'b1;
                        state        <= st_launch;
                    end
                end

                st_launch: state <= st_wait;

                st_wait: begin
                    wd_cnt <= wd_next;
                    // Completion takes priority over a watchdog expiry in the same cycle.
                    if (i2c_done_i) begin
                        rsp_data_o  <= i2c_data_i;
                        rsp_err_o   <= 1'b0;
                        rsp_valid_o <= one_lsb << grant_o;
                        state       <= st_recover;
                    end else if (wd_expired) begin
                        rsp_data_o  <= '0;
                        rsp_err_o   <= 1'b1;
                        rsp_valid_o <= one_lsb << grant_o;
                        state       <= st_recover;
                    end
                end

                st_recover: begin
                    if (i2c_ready_i) state <= st_idle;
                end

                default: state <= st_idle;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Self-checking bench for i2c_arbiter: directed steps plus randomized transactions
// checked against a round-robin reference model and an engine model.
module tb_i2c_arbiter;

    localparam int n_req   = 4;
    localparam int nbytes  = 3;
    localparam int timeout = 50;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [7:0]  nbytes_in;
    logic [95:0] data_in;
    logic [3:0]  ack;
    logic [3:0]  rsp_valid;
    logic [23:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic [1:0]  grant;
    logic        send;
    logic [1:0]  i2c_nbytes;
    logic [23:0] i2c_data_out;
    logic [23:0] i2c_rdata;
    logic        done;
    logic        ready;

    i2c_arbiter #(
        .n_req_g  (n_req),
        .nbytes_g (nbytes),
        .timeout_g(timeout)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .req_i       (req),
        .nbytes_i    (nbytes_in),
        .data_i      (data_in),
        .ack_o       (ack),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_data),
        .rsp_err_o   (rsp_err),
        .busy_o      (busy),
        .grant_o     (grant),
        .i2c_send_o  (send),
        .i2c_nbytes_o(i2c_nbytes),
        .i2c_data_o  (i2c_data_out),
        .i2c_data_i  (i2c_rdata),
        .i2c_done_i  (done),
        .i2c_ready_i (ready)
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    int          exp_ptr     = 0;
    int          cur_w       = 0;
    int          waited;
    int          cycles;
    logic [23:0] pay [4];
    logic [1:0]  nb  [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference arbitration: first pending requester at or after ptr, wrapping.
    function automatic int pick(input logic [3:0] r, input int ptr);
        for (int k = 0; k < n_req; k++) begin
            int idx;
            idx = (ptr + k) % n_req;
            if (r[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    task automatic drive_payloads();
        for (int k = 0; k < n_req; k++) begin
            data_in[k*24 +: 24] = pay[k];
            nbytes_in[k*2 +: 2] = nb[k];
        end
    endtask

    task automatic new_payload(input int k);
        pay[k] = 24'($urandom);
        nb[k]  = 2'($urandom_range(0, 3));
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_ack"}, ack, 0);
        check({pfx, "_rsp_valid"}, rsp_valid, 0);
        check({pfx, "_rsp_data"}, rsp_data, 0);
        check({pfx, "_rsp_err"}, rsp_err, 0);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_grant"}, grant, 0);
        check({pfx, "_send"}, send, 0);
        check({pfx, "_i2c_nbytes"}, i2c_nbytes, 0);
        check({pfx, "_i2c_data"}, i2c_data_out, 0);
    endtask

    // Waits (bounded) for the launch cycle and checks grant, ack and latched payload.
    task automatic expect_launch(input int max_wait, output int n);
        int w;
        w = pick(req, exp_ptr);
        n = 0;
        while (send !== 1'b1 && n < max_wait) begin
            @(negedge clk);
            n++;
        end
        check("launch_seen", send, 1);
        check("ack_onehot", ack, 32'd1 << w);
        check("grant", grant, w);
        check("i2c_data", i2c_data_out, pay[w]);
        check("i2c_nbytes", i2c_nbytes, nb[w]);
        check("busy_launch", busy, 1);
        cur_w   = w;
        exp_ptr = (w + 1) % n_req;
    endtask

    // Engine model: busy after launch, done after latency WAIT cycles, ready after rdelay.
    task automatic complete(input int latency, input logic [23:0] rdata, input int rdelay, input bit keep);
        if (keep) begin
            new_payload(cur_w);
            drive_payloads();
        end else begin
            req[cur_w] = 1'b0;
        end
        ready = 1'b0;
        @(negedge clk);
        check("ack_one_cycle", ack, 0);
        check("send_one_cycle", send, 0);
        repeat (latency - 1) @(negedge clk);
        i2c_rdata = rdata;
        done      = 1'b1;
        @(negedge clk);
        done      = 1'b0;
        i2c_rdata = 24'($urandom);
        check("rsp_valid", rsp_valid, 32'd1 << cur_w);
        check("rsp_data", rsp_data, rdata);
        check("rsp_err", rsp_err, 0);
        for (int d = 0; d < rdelay; d++) begin
            @(negedge clk);
            check("recover_busy", busy, 1);
            check("recover_no_ack", ack, 0);
        end
        ready = 1'b1;
        @(negedge clk);
        check("rsp_valid_pulse", rsp_valid, 0);
        check("idle_after_recover", busy, 0);
        check("rsp_data_held", rsp_data, rdata);
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        data_in   = '0;
        nbytes_in = '0;
        i2c_rdata = '0;
        done      = 1'b0;
        ready     = 1'b1;
        for (int k = 0; k < n_req; k++) new_payload(k);
        drive_payloads();

        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset");

        // Single request with fixed payload and response
        pay[1] = 24'hA55A42;
        nb[1]  = 2'd2;
        drive_payloads();
        req = 4'b0010;
        expect_launch(8, waited);
        check("single_latency", waited, 1);
        complete(3, 24'h00003C, 0, 1'b0);

        // Ready gating: nothing happens while the engine is not ready
        ready = 1'b0;
        req   = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("gated_ack", ack, 0);
            check("gated_send", send, 0);
            check("gated_busy", busy, 0);
        end
        ready = 1'b1;
        expect_launch(8, waited);
        check("gated_grant_delay", waited, 1);
        complete(1, 24'($urandom), 1, 1'b0);

        // Randomized transactions against the reference model
        for (int t = 0; t < 12; t++) begin
            req = req | 4'($urandom);
            if (req == 4'b0000) req = 4'b1000;
            for (int k = 0; k < n_req; k++) new_payload(k);
            drive_payloads();
            expect_launch(8, waited);
            complete($urandom_range(1, 49), 24'($urandom), $urandom_range(0, 3), 1'($urandom));
        end

        // Watchdog: engine never completes
        req = 4'b0100;
        expect_launch(8, waited);
        req    = 4'b1001;
        ready  = 1'b0;
        cycles = 0;
        while (rsp_valid == 4'b0000 && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
        check("wd_latency", cycles, timeout + 1);
        check("wd_rsp_valid", rsp_valid, 4'b0100);
        check("wd_rsp_err", rsp_err, 1);
        check("wd_rsp_data", rsp_data, 0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("wd_hold_no_ack", ack, 0);
            check("wd_hold_busy", busy, 1);
        end
        ready = 1'b1;
        expect_launch(8, waited);
        check("wd_regrant_delay", waited, 2);
        complete(4, 24'($urandom), 0, 1'b0);
        req = '0;

        // Done exactly on the expiry cycle, and one cycle before it
        req = 4'b0010;
        expect_launch(8, waited);
        complete(timeout, 24'h5AC3E1, 1, 1'b0);
        req = 4'b1000;
        expect_launch(8, waited);
        complete(timeout - 1, 24'h13579B, 0, 1'b0);

        // Asynchronous reset in the middle of WAIT
        req = 4'b0100;
        expect_launch(8, waited);
        req   = 4'b0000;
        ready = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        exp_ptr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b1111;
        for (int k = 0; k < n_req; k++) new_payload(k);
        drive_payloads();
        repeat (3) begin
            @(negedge clk);
            check("reset_wait_ready", send, 0);
        end
        ready = 1'b1;

        // Fairness: all requesters keep requesting, grants rotate from 0
        for (int t = 0; t < 8; t++) begin
            expect_launch(8, waited);
            check("fair_order", grant, t % n_req);
            complete($urandom_range(1, 5), 24'($urandom), $urandom_range(0, 1), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL global_timeout: observed no completion, required finish before 2ms");
        $fatal(1, "simulation time limit reached");
    end

endmodule
